// File: rtl/l2_pkg.sv
// rtl/l2_pkg.sv - shared defaults and FSM state encoding for the L2 data bank
package l2_pkg;

  localparam int SETS_DEF   = 16;
  localparam int WAYS_DEF   = 4;
  localparam int LINE_W_DEF = 512;
  localparam int BEAT_W_DEF = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_FILL_WR,
    ST_EV_RD,
    ST_EV_SEND
  } state_e;

endpackage

// File: rtl/l2_bram_be.sv
// rtl/l2_bram_be.sv - single-address line RAM with byte-enable write and registered read-first read
module l2_bram_be #(
  parameter int DEPTH  = 64,
  parameter int LINE_W = 512
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     re,
  input  logic                     we,
  input  logic [LINE_W/8-1:0]      be,
  input  logic [LINE_W-1:0]        wdata,
  output logic [LINE_W-1:0]        rdata
);

  logic [LINE_W-1:0] mem [DEPTH];
  logic [LINE_W-1:0] rdata_q;

  // No reset on storage or output register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LINE_W/8; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/l2_data_bank.sv
// rtl/l2_data_bank.sv - L2 data array with byte-enable hits and beat-serialised refill/evict bursts
module l2_data_bank
  import l2_pkg::*;
#(
  parameter int SETS   = SETS_DEF,
  parameter int WAYS   = WAYS_DEF,
  parameter int LINE_W = LINE_W_DEF,
  parameter int BEAT_W = BEAT_W_DEF,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS),
  localparam int BE_W  = LINE_W / 8,
  localparam int BEATS = LINE_W / BEAT_W,
  localparam int BC_W  = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [IDX_W-1:0]  index,
  input  logic [WAY_W-1:0]  way,
  input  logic              rd_en,
  output logic              rd_valid,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              fill_start,
  input  logic              fill_valid,
  output logic              fill_ready,
  input  logic [BEAT_W-1:0] fill_data,
  output logic              fill_done,
  input  logic              ev_start,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [BEAT_W-1:0] ev_data,
  output logic              ev_last,
  output logic              busy
);

  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);

  state_e            state_q, state_d;
  logic [BC_W-1:0]   cnt_q, cnt_d;
  logic [LINE_W-1:0] buf_q, buf_d;
  logic [LINE_W-1:0] rd_hold_q, rd_hold_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WAY_W-1:0]  way_q, way_d;
  logic              rd_valid_q, rd_valid_d;

  logic                   idle, rd_acc, wr_acc;
  logic                   ram_re, ram_we;
  logic [BE_W-1:0]        ram_be;
  logic [LINE_W-1:0]      ram_wdata, ram_rdata;
  logic [IDX_W+WAY_W-1:0] ram_addr;

  assign idle   = (state_q == ST_IDLE);
  assign rd_acc = idle && rd_en && !ev_start && !fill_start;
  assign wr_acc = idle && wr_en && !ev_start && !fill_start;

  // In IDLE the RAM follows the live request; bursts use the latched set/way.
  assign ram_addr  = idle ? {index, way} : {idx_q, way_q};
  assign ram_re    = rd_acc || (idle && ev_start);
  assign ram_we    = wr_acc || (state_q == ST_FILL_WR);
  assign ram_be    = idle ? wr_be : '1;
  assign ram_wdata = idle ? wr_data : buf_q;

  l2_bram_be #(
    .DEPTH  (SETS * WAYS),
    .LINE_W (LINE_W)
  ) u_bram (
    .clk   (clk),
    .addr  (ram_addr),
    .re    (ram_re),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    way_d      = way_q;
    rd_valid_d = rd_acc;
    // Shadow the read result so an eviction read cannot disturb rd_data.
    rd_hold_d  = rd_valid_q ? ram_rdata : rd_hold_q;
    case (state_q)
      ST_IDLE: begin
        if (ev_start) begin
          state_d = ST_EV_RD;
          idx_d   = index;
          way_d   = way;
        end else if (fill_start) begin
          state_d = ST_FILL;
          idx_d   = index;
          way_d   = way;
        end
      end
      ST_FILL: begin
        if (fill_valid) begin
          buf_d[cnt_q*BEAT_W +: BEAT_W] = fill_data;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = ST_FILL_WR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_FILL_WR: state_d = ST_IDLE;
      ST_EV_RD: begin
        buf_d   = ram_rdata;
        cnt_d   = '0;
        state_d = ST_EV_SEND;
      end
      ST_EV_SEND: begin
        if (ev_ready) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      buf_q      <= '0;
      rd_hold_q  <= '0;
      idx_q      <= '0;
      way_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      rd_hold_q  <= rd_hold_d;
      idx_q      <= idx_d;
      way_q      <= way_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_valid_q ? ram_rdata : rd_hold_q;
  assign fill_ready = (state_q == ST_FILL);
  assign fill_done  = (state_q == ST_FILL_WR);
  assign ev_valid   = (state_q == ST_EV_SEND);
  assign ev_data    = buf_q[cnt_q*BEAT_W +: BEAT_W];
  assign ev_last    = ev_valid && (cnt_q == LAST_BEAT);
  assign busy       = !idle;

endmodule

// File: tb/tb_l2_data_bank.sv
// tb/tb_l2_data_bank.sv - randomized self-checking bench for l2_data_bank against a line-array model
module tb_l2_data_bank;
  import l2_pkg::*;

  localparam int SETS   = SETS_DEF;
  localparam int WAYS   = WAYS_DEF;
  localparam int LINE_W = LINE_W_DEF;
  localparam int BEAT_W = BEAT_W_DEF;
  localparam int IDX_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int BE_W   = LINE_W / 8;
  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int NLINES = SETS * WAYS;

  logic              clk = 1'b0;
  logic              nrst;
  logic [IDX_W-1:0]  index;
  logic [WAY_W-1:0]  way;
  logic              rd_en, rd_valid;
  logic [LINE_W-1:0] rd_data;
  logic              wr_en;
  logic [BE_W-1:0]   wr_be;
  logic [LINE_W-1:0] wr_data;
  logic              fill_start, fill_valid, fill_ready, fill_done;
  logic [BEAT_W-1:0] fill_data;
  logic              ev_start, ev_valid, ev_ready, ev_last;
  logic [BEAT_W-1:0] ev_data;
  logic              busy;

  l2_data_bank dut (
    .clk        (clk),
    .nrst       (nrst),
    .index      (index),
    .way        (way),
    .rd_en      (rd_en),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_be      (wr_be),
    .wr_data    (wr_data),
    .fill_start (fill_start),
    .fill_valid (fill_valid),
    .fill_ready (fill_ready),
    .fill_data  (fill_data),
    .fill_done  (fill_done),
    .ev_start   (ev_start),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_data    (ev_data),
    .ev_last    (ev_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [LINE_W-1:0] mem_m [NLINES];
  bit                vld_m [NLINES];
  int                n_checks = 0;
  int                n_errors = 0;

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                          input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rnd_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W/32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [BE_W-1:0] rnd_be();
    logic [BE_W-1:0] b;
    for (int i = 0; i < BE_W/32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [LINE_W-1:0] merge(input logic [LINE_W-1:0] old_l,
                                               input logic [LINE_W-1:0] new_l,
                                               input logic [BE_W-1:0] be);
    logic [LINE_W-1:0] r = old_l;
    for (int i = 0; i < BE_W; i++) if (be[i]) r[i*8 +: 8] = new_l[i*8 +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    rd_en = 0; wr_en = 0; wr_be = '0; wr_data = '0;
    fill_start = 0; fill_valid = 0; fill_data = '0;
    ev_start = 0; ev_ready = 0;
  endtask

  task automatic do_write(input int idx, input int w, input logic [LINE_W-1:0] d,
                          input logic [BE_W-1:0] be, input bit with_rd);
    int a = idx * WAYS + w;
    index = IDX_W'(idx); way = WAY_W'(w);
    wr_en = 1; wr_be = be; wr_data = d; rd_en = with_rd;
    step();
    wr_en = 0; rd_en = 0;
    if (with_rd) begin
      check_eq("rdwr_valid", LINE_W'(rd_valid), 1);
      check_eq("rdwr_old_data", rd_data, mem_m[a]);
    end
    mem_m[a] = merge(mem_m[a], d, be);
    vld_m[a] = 1;
  endtask

  task automatic do_read(input int idx, input int w);
    int a = idx * WAYS + w;
    index = IDX_W'(idx); way = WAY_W'(w); rd_en = 1;
    step();
    rd_en = 0;
    index = IDX_W'($urandom); way = WAY_W'($urandom);
    check_eq("rd_valid", LINE_W'(rd_valid), 1);
    check_eq("rd_data", rd_data, mem_m[a]);
    step();
    check_eq("rd_valid_drop", LINE_W'(rd_valid), 0);
    check_eq("rd_data_hold", rd_data, mem_m[a]);
  endtask

  // abort_at < 0 runs a full fill; otherwise reset is pulsed after that many beats.
  task automatic do_fill(input int idx, input int w, input logic [LINE_W-1:0] line,
                         input int abort_at);
    int a = idx * WAYS + w;
    int k = 0;
    int guard = 0;
    int dones = 0;
    index = IDX_W'(idx); way = WAY_W'(w); fill_start = 1;
    step();
    fill_start = 0;
    check_eq("fill_busy", LINE_W'(busy), 1);
    check_eq("fill_ready", LINE_W'(fill_ready), 1);
    while (k < BEATS && guard < 200) begin
      if (k == abort_at) begin
        fill_valid = 0;
        nrst = 0;
        #1;
        check_eq("abort_busy", LINE_W'(busy), 0);
        check_eq("abort_fill_ready", LINE_W'(fill_ready), 0);
        step();
        nrst = 1;
        step();
        return;
      end
      index = IDX_W'($urandom); way = WAY_W'($urandom);
      fill_valid = ($urandom_range(0, 2) != 0);
      fill_data = line[k*BEAT_W +: BEAT_W];
      step();
      if (fill_valid) k++;
      if (fill_done) dones++;
      guard++;
    end
    fill_valid = 0;
    check_eq("fill_beats", LINE_W'(k), LINE_W'(BEATS));
    step();
    if (fill_done) dones++;
    check_eq("fill_done_once", LINE_W'(dones), 1);
    check_eq("fill_idle", LINE_W'(busy), 0);
    mem_m[a] = line;
    vld_m[a] = 1;
  endtask

  task automatic do_evict(input int idx, input int w, input bit toggle, input bit with_fill);
    int a = idx * WAYS + w;
    int k = 0;
    int guard = 0;
    index = IDX_W'(idx); way = WAY_W'(w); ev_start = 1; fill_start = with_fill;
    step();
    ev_start = 0; fill_start = 0;
    index = IDX_W'($urandom); way = WAY_W'($urandom);
    check_eq("ev_rd_busy", LINE_W'(busy), 1);
    check_eq("ev_rd_valid", LINE_W'(ev_valid), 0);
    check_eq("ev_no_fill", LINE_W'(fill_ready), 0);
    step();
    while (k < BEATS && guard < 200) begin
      check_eq("ev_valid", LINE_W'(ev_valid), 1);
      check_eq("ev_data", LINE_W'(ev_data), LINE_W'(mem_m[a][k*BEAT_W +: BEAT_W]));
      check_eq("ev_last", LINE_W'(ev_last), LINE_W'(k == BEATS - 1));
      ev_ready = toggle ? ((guard % 2) == 0) : ($urandom_range(0, 1) == 1);
      step();
      if (ev_ready) k++;
      guard++;
    end
    ev_ready = 0;
    check_eq("ev_beats", LINE_W'(k), LINE_W'(BEATS));
    check_eq("ev_idle", LINE_W'(busy), 0);
    check_eq("ev_valid_drop", LINE_W'(ev_valid), 0);
  endtask

  initial begin
    logic [LINE_W-1:0] pat_a, pat_b, fl;
    logic [BE_W-1:0]   be_lo;
    nrst = 0;
    index = '0; way = '0;
    idle_inputs();
    for (int i = 0; i < NLINES; i++) begin
      mem_m[i] = '0;
      vld_m[i] = 0;
    end
    step();
    step();
    check_eq("rst_rd_valid", LINE_W'(rd_valid), 0);
    check_eq("rst_rd_data", rd_data, '0);
    check_eq("rst_busy", LINE_W'(busy), 0);
    check_eq("rst_fill_ready", LINE_W'(fill_ready), 0);
    check_eq("rst_fill_done", LINE_W'(fill_done), 0);
    check_eq("rst_ev_valid", LINE_W'(ev_valid), 0);
    check_eq("rst_ev_last", LINE_W'(ev_last), 0);
    check_eq("rst_ev_data", LINE_W'(ev_data), '0);
    nrst = 1;
    step();

    pat_a = rnd_line();
    do_write(3, 2, pat_a, '1, 0);
    do_read(3, 2);

    pat_b = rnd_line();
    be_lo = BE_W'(4'hF);
    do_write(3, 2, pat_b, be_lo, 0);
    do_read(3, 2);
    do_write(3, 2, rnd_line(), '0, 0);
    do_read(3, 2);

    fl = {{(BEAT_W/8){8'h44}}, {(BEAT_W/8){8'h33}}, {(BEAT_W/8){8'h22}}, {(BEAT_W/8){8'h11}}};
    do_fill(5, 1, fl, -1);
    do_read(5, 1);
    do_evict(5, 1, 1, 0);

    do_write(3, 2, rnd_line(), rnd_be(), 1);
    do_read(3, 2);
    do_evict(3, 2, 0, 1);

    do_fill(5, 1, rnd_line(), 2);
    do_read(5, 1);

    for (int n = 0; n < 60; n++) begin
      int idx = $urandom_range(0, SETS - 1);
      int w = $urandom_range(0, WAYS - 1);
      int op = $urandom_range(0, 4);
      if (!vld_m[idx*WAYS + w]) do_write(idx, w, rnd_line(), '1, 0);
      case (op)
        0: do_write(idx, w, rnd_line(), rnd_be(), 0);
        1: do_read(idx, w);
        2: do_fill(idx, w, rnd_line(), -1);
        3: do_evict(idx, w, 0, $urandom_range(0, 1) == 1);
        default: do_write(idx, w, rnd_line(), rnd_be(), 1);
      endcase
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
